ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes each PC value and issues a word read to instruction memory (IM), which grants requests and returns responses in order after a variable latency.
- Pairs each returned instruction with its PC and buffers the pairs in an in-order queue that feeds decode over a valid/ready handshake.
- Supports a single-cycle flush for branch/jump redirect, which discards everything buffered and everything still in flight.

Parameters:
- DEPTH, 4, number of queue entries; power of two, range 2..16; also the cap on issued-but-not-consumed fetches.
- CNT_W, 3, width of the occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- pc_in  in  32  fetch address from the PC register.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  pc_in is accepted this cycle; the PC may advance.
- im_req  out  1  IM read request.
- im_addr  out  32  IM word address, equal to {pc_in[31:2],2'b00}.
- im_gnt  in  1  IM accepts the request this cycle.
- im_rvalid  in  1  IM returns read data; responses are in request order, minimum latency 1 cycle after grant.
- im_rdata  in  32  instruction word.
- flush  in  1  redirect; discard all entries and all in-flight responses.
- out_valid  out  1  head entry holds a complete instruction.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- out_ready  in  1  decode consumes the head entry.
- occupancy  out  CNT_W  number of allocated entries, filled or pending.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears wr/rd/fill pointers, occupancy, drop counter and all entry fill bits.
  - out_valid=0, out_pc=0, out_instr=0, occupancy=0.
  - im_req and pc_ready are forced to 0 while reset=0.
- Issue path (combinational):
  - im_req = pc_valid & (occupancy<DEPTH) & ~flush.
  - pc_ready = im_req & im_gnt.
- Issue fire (pc_ready=1): at the clock edge, allocate the entry at wr_ptr, store its pc, clear its fill bit, advance wr_ptr modulo DEPTH, and increment occupancy.
- Response path:
  - When im_rvalid=1 and drop_cnt=0, write im_rdata into the entry at fill_ptr, set its fill bit, and advance fill_ptr.
  - When im_rvalid=1 and drop_cnt>0, discard the data and decrement drop_cnt.
- Output path:
  - out_valid = fill bit of the entry at rd_ptr; out_pc and out_instr are driven from that entry.
  - Consume fire is out_valid & out_ready: advance rd_ptr and decrement occupancy.
  - A same-cycle issue and consume leave occupancy unchanged.
- Latency:
  - A response arriving at cycle N is visible on out_valid at N+1.
  - Best case is issue at cycle T and out_valid at T+2 with 1-cycle IM latency.
- Full (occupancy=DEPTH): im_req=0 and pc_ready=0. A consume in that cycle does not free credit until the next cycle; there is no same-cycle bypass.
- Empty, or head entry unfilled: out_valid=0, and out_pc/out_instr hold their last values. Decode must ignore them.
- Flush (registered effect at the clock edge):
  - Reset all pointers and occupancy to 0 and clear all fill bits.
  - New drop_cnt = drop_cnt + (entries pending without a response) − (1 if im_rvalid was discarded or accepted this cycle and counted as pending).
  - In effect, every response not yet returned at the flush edge is dropped exactly once.
  - No issue occurs in a flush cycle. A consume in the same cycle is ignored, because the entry is discarded anyway.
- Fetch during drop: issue is allowed while drop_cnt>0. New responses arrive after the dropped ones because IM is in order.
- Wrap-around: all pointers are log2(DEPTH) bits and wrap naturally. occupancy disambiguates full from empty.
- Protocol check: im_rvalid with no pending entry and drop_cnt=0 is a protocol error. The bench asserts it never happens; RTL ignores the data.
- Pipeline requirement: the block never stalls IM and holds no combinational path from im_rvalid to out_valid.

Test Plan:
- Reset then streaming: release reset with pc_valid=1 and pc_in=0x3000, 0x3004, 0x3008 held per pc_ready, IM grants every cycle with latency 1, out_ready=1 → out_pc sequence 0x3000, 0x3004, 0x3008; first out_valid 2 cycles after the first grant; occupancy never exceeds 2.
- Backpressure to full: out_ready=0, IM latency 1, DEPTH=4 → exactly 4 grants, then pc_ready=0 and occupancy=4. Raising out_ready for 1 cycle → next issue is 1 cycle later at pc_in=0x3010.
- Variable latency: IM latencies 3, 1, 2 for PCs 0x3000, 0x3004, 0x3008 with in-order data 0xA, 0xB, 0xC → outputs pair 0x3000/0xA, 0x3004/0xB, 0x3008/0xC.
- Flush with in-flight responses: 3 requests granted, IM latency 4, flush one cycle later, then pc_in=0x4000 → the 3 stale responses are dropped; the first out_pc is 0x4000 with its own data; occupancy=0 right after the flush.
- Flush coincident with im_rvalid: a response arrives in the flush cycle with 2 pending → drop_cnt=1 afterwards; only the next response is discarded.
- Asynchronous reset mid-operation: assert reset=0 between clock edges while occupancy=3 → occupancy, out_valid and im_req go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch queue: issues PC-driven word reads to IM, pairs the in-order
// responses with their PCs and hands them to decode over valid/ready, with flush.
module ifu_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic             pc_valid,
  output logic             pc_ready,
  output logic             im_req,
  output logic [31:0]      im_addr,
  input  logic             im_gnt,
  input  logic             im_rvalid,
  input  logic [31:0]      im_rdata,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DROP_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DEPTH-1:0]  fill_q, fill_d;
  logic [31:0]       hold_pc_q, hold_pc_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];

  logic head_valid;
  logic consume;
  logic rsp_drop;
  logic rsp_acc;

  assign im_req     = reset & pc_valid & (occ_q != FULL) & ~flush;
  assign pc_ready   = im_req & im_gnt;
  assign im_addr    = {pc_in[31:2], 2'b00};
  assign head_valid = fill_q[rd_ptr_q];
  assign out_valid  = head_valid;
  assign out_pc     = head_valid ? pc_q[rd_ptr_q]    : hold_pc_q;
  assign out_instr  = head_valid ? instr_q[rd_ptr_q] : hold_instr_q;
  assign occupancy  = occ_q;
  assign consume    = head_valid & out_ready & ~flush;
  assign rsp_drop   = im_rvalid & (drop_q != '0);
  assign rsp_acc    = im_rvalid & (drop_q == '0) & (pend_q != '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    occ_d        = occ_q;
    pend_d       = pend_q;
    drop_d       = drop_q;
    fill_d       = fill_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if (head_valid) begin
      hold_pc_d    = pc_q[rd_ptr_q];
      hold_instr_d = instr_q[rd_ptr_q];
    end
    if (flush) begin
      // Every response not yet returned must be swallowed exactly once later on.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_ptr_d = '0;
      occ_d      = '0;
      pend_d     = '0;
      fill_d     = '0;
      drop_d     = drop_q + DROP_W'(pend_q) - DROP_W'(rsp_drop | rsp_acc);
    end else begin
      if (rsp_drop) begin
        drop_d = drop_q - DROP_W'(1);
      end
      if (rsp_acc) begin
        fill_d[fill_ptr_q] = 1'b1;
        fill_ptr_d         = fill_ptr_q + PTR_W'(1);
      end
      if (consume) begin
        fill_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      end
      if (pc_ready) begin
        fill_d[wr_ptr_q] = 1'b0;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      occ_d  = occ_q + CNT_W'(pc_ready) - CNT_W'(consume);
      pend_d = pend_q + CNT_W'(pc_ready) - CNT_W'(rsp_acc);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_ptr_q   <= '0;
      occ_q        <= '0;
      pend_q       <= '0;
      drop_q       <= '0;
      fill_q       <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      occ_q        <= occ_d;
      pend_q       <= pend_d;
      drop_q       <= drop_d;
      fill_q       <= fill_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Payload storage needs no reset; fill bits decide what is visible.
  always_ff @(posedge clk) begin
    if (pc_ready) begin
      pc_q[wr_ptr_q] <= pc_in;
    end
    if (rsp_acc && !flush) begin
      instr_q[fill_ptr_q] <= im_rdata;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: queue-level reference model checked every
// cycle, an in-order variable-latency IM responder, and directed scenario checks.
module tb_ifu_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      pc_in = 32'h0;
  logic             pc_valid = 1'b0;
  logic             pc_ready;
  logic             im_req;
  logic [31:0]      im_addr;
  logic             im_gnt = 1'b1;
  logic             im_rvalid = 1'b0;
  logic [31:0]      im_rdata = 32'h0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] occupancy;

  ifu_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid),
    .im_rdata(im_rdata), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  ent_t        mq[$];
  int          drop = 0;
  rsp_t        rq[$];
  int          lat_q[$];
  logic [31:0] dat_q[$];
  int          lat_def = 1;
  int          last_due = -1;
  int          cyc = 0;
  int          issue_left = 0;
  logic [31:0] gpc_q[$];
  int          gcyc_q[$];
  logic [31:0] cpc_q[$];
  logic [31:0] cins_q[$];
  int          vcyc_q[$];
  int          maxOcc = 0;
  int          nChecks = 0;
  int          nFail = 0;
  int          relCyc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of {pc, instr, filled} plus a count of responses to drop.
  always @(negedge clk) begin : cmp
    int  unf;
    bit  er, ev, found;
    if (!reset) begin
      checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_im_req", 32'(im_req), 32'h0);
      checkOutput("rst_pc_ready", 32'(pc_ready), 32'h0);
    end else begin
      er = pc_valid && (mq.size() < DEPTH) && !flush;
      ev = (mq.size() > 0) && mq[0].filled;
      checkOutput("im_req", 32'(im_req), 32'(er));
      checkOutput("pc_ready", 32'(pc_ready), 32'(er && im_gnt));
      checkOutput("occupancy", 32'(occupancy), 32'(mq.size()));
      checkOutput("out_valid", 32'(out_valid), 32'(ev));
      if (er) checkOutput("im_addr", im_addr, {pc_in[31:2], 2'b00});
      if (ev) begin
        checkOutput("out_pc", out_pc, mq[0].pc);
        checkOutput("out_instr", out_instr, mq[0].instr);
      end
      if (32'(occupancy) > maxOcc) maxOcc = 32'(occupancy);
      if (pc_ready) begin gpc_q.push_back(pc_in); gcyc_q.push_back(cyc); end
      if (out_valid) vcyc_q.push_back(cyc);
      if (out_valid && out_ready && !flush) begin
        cpc_q.push_back(out_pc);
        cins_q.push_back(out_instr);
      end
      if (flush) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        drop = drop + unf - ((im_rvalid && (drop > 0 || unf > 0)) ? 1 : 0);
        mq.delete();
      end else begin
        if (ev && out_ready) void'(mq.pop_front());
        if (im_rvalid) begin
          if (drop > 0) begin
            drop--;
          end else begin
            found = 0;
            foreach (mq[i]) begin
              if (!found && !mq[i].filled) begin
                mq[i].filled = 1;
                mq[i].instr  = im_rdata;
                found = 1;
              end
            end
            nChecks++;
            if (!found) begin
              nFail++;
              $display("[TB] FAIL im_protocol: response with nothing pending (cycle %0d)", cyc);
            end
          end
        end
        if (er && im_gnt) mq.push_back('{pc_in, 32'h0, 1'b0});
      end
    end
  end

  // One clock: IM responder bookkeeping at the negedge, new inputs just after the posedge.
  task automatic step();
    bit          fire;
    int          l, due;
    logic [31:0] d;
    @(negedge clk);
    fire = reset && pc_ready;
    if (im_rvalid && rq.size() > 0) void'(rq.pop_front());
    if (fire) begin
      l   = (lat_q.size() > 0) ? lat_q.pop_front() : lat_def;
      due = cyc + l;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      d = (dat_q.size() > 0) ? dat_q.pop_front() : (pc_in ^ K);
      rq.push_back('{due, d});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fire) begin
      pc_in = pc_in + 32'd4;
      if (issue_left > 0) issue_left--;
      if (issue_left == 0) pc_valid = 1'b0;
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      im_rvalid = 1'b1;
      im_rdata  = rq[0].data;
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = 32'h0;
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic applyReset();
    reset = 1'b0;
    pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; im_gnt = 1'b1;
    im_rvalid = 1'b0; im_rdata = 32'h0; issue_left = 0; lat_def = 1;
    rq.delete(); lat_q.delete(); dat_q.delete(); mq.delete(); drop = 0; last_due = -1;
    gpc_q.delete(); gcyc_q.delete(); cpc_q.delete(); cins_q.delete(); vcyc_q.delete();
    maxOcc = 0;
    applyStimulus(2);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values, with a valid PC presented so im_req/pc_ready masking is exercised.
    applyStimulus(1);
    pc_valid = 1'b1;
    pc_in = 32'h3000;
    #1;
    checkOutput("reset_occupancy", 32'(occupancy), 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_out_pc", out_pc, 32'h0);
    checkOutput("reset_out_instr", out_instr, 32'h0);
    checkOutput("reset_im_req", 32'(im_req), 32'h0);
    checkOutput("reset_pc_ready", 32'(pc_ready), 32'h0);

    // Streaming with 1-cycle IM latency.
    applyStimulus(1);
    reset = 1'b1; issue_left = 3; lat_def = 1; out_ready = 1'b1; im_gnt = 1'b1;
    applyStimulus(8);
    checkOutput("s1_count", 32'(cpc_q.size()), 32'd3);
    if (cpc_q.size() == 3) begin
      checkOutput("s1_pc0", cpc_q[0], 32'h3000);
      checkOutput("s1_pc1", cpc_q[1], 32'h3004);
      checkOutput("s1_pc2", cpc_q[2], 32'h3008);
      checkOutput("s1_ins2", cins_q[2], 32'h5A5A_3008);
    end
    if (vcyc_q.size() > 0 && gcyc_q.size() > 0)
      checkOutput("s1_first_latency", 32'(vcyc_q[0] - gcyc_q[0]), 32'd2);
    else checkOutput("s1_first_valid_seen", 32'd0, 32'd1);
    checkOutput("s1_max_occ_le2", 32'(maxOcc <= 2), 32'd1);

    // Backpressure until full, then one consume frees one credit a cycle later.
    applyReset();
    pc_valid = 1'b1; pc_in = 32'h3000; issue_left = 8; out_ready = 1'b0;
    applyStimulus(6);
    checkOutput("s2_grants", 32'(gpc_q.size()), 32'd4);
    checkOutput("s2_occ_full", 32'(occupancy), 32'd4);
    checkOutput("s2_pc_ready_full", 32'(pc_ready), 32'd0);
    relCyc = cyc;
    out_ready = 1'b1;
    applyStimulus(1);
    out_ready = 1'b0;
    applyStimulus(2);
    checkOutput("s2_grants_after", 32'(gpc_q.size()), 32'd5);
    if (gpc_q.size() == 5) begin
      checkOutput("s2_next_pc", gpc_q[4], 32'h3010);
      checkOutput("s2_next_cycle", 32'(gcyc_q[4] - relCyc), 32'd1);
    end
    checkOutput("s2_occ_refull", 32'(occupancy), 32'd4);

    // Variable latency 3,1,2 with explicit data words.
    applyReset();
    lat_q = '{3, 1, 2};
    dat_q = '{32'hA, 32'hB, 32'hC};
    pc_valid = 1'b1; pc_in = 32'h3000; issue_left = 3; out_ready = 1'b1;
    applyStimulus(10);
    checkOutput("s3_count", 32'(cpc_q.size()), 32'd3);
    if (cpc_q.size() == 3) begin
      checkOutput("s3_pc0", cpc_q[0], 32'h3000);
      checkOutput("s3_ins0", cins_q[0], 32'hA);
      checkOutput("s3_pc1", cpc_q[1], 32'h3004);
      checkOutput("s3_ins1", cins_q[1], 32'hB);
      checkOutput("s3_pc2", cpc_q[2], 32'h3008);
      checkOutput("s3_ins2", cins_q[2], 32'hC);
    end

    // Flush with three responses still in flight (latency 4).
    applyReset();
    lat_def = 4; pc_valid = 1'b1; pc_in = 32'h3000; issue_left = 3; out_ready = 1'b1;
    applyStimulus(3);
    flush = 1'b1;
    applyStimulus(1);
    flush = 1'b0;
    checkOutput("s4_occ_after_flush", 32'(occupancy), 32'd0);
    pc_in = 32'h4000; pc_valid = 1'b1; issue_left = 1;
    applyStimulus(9);
    checkOutput("s4_count", 32'(cpc_q.size()), 32'd1);
    if (cpc_q.size() > 0) begin
      checkOutput("s4_pc", cpc_q[0], 32'h4000);
      checkOutput("s4_ins", cins_q[0], 32'h5A5A_4000);
    end

    // Flush in the same cycle a response returns, two requests pending.
    applyReset();
    lat_def = 2; pc_valid = 1'b1; pc_in = 32'h3000; issue_left = 2; out_ready = 1'b1;
    applyStimulus(2);
    flush = 1'b1;
    applyStimulus(1);
    flush = 1'b0;
    pc_in = 32'h5000; pc_valid = 1'b1; issue_left = 1;
    applyStimulus(6);
    checkOutput("s5_count", 32'(cpc_q.size()), 32'd1);
    if (cpc_q.size() > 0) begin
      checkOutput("s5_pc", cpc_q[0], 32'h5000);
      checkOutput("s5_ins", cins_q[0], 32'h5A5A_5000);
    end

    // Asynchronous reset between edges with three entries held.
    applyReset();
    pc_valid = 1'b1; pc_in = 32'h3000; issue_left = 3; out_ready = 1'b0;
    applyStimulus(4);
    im_gnt = 1'b0; pc_valid = 1'b1;
    #2;
    checkOutput("s6_pre_occ", 32'(occupancy), 32'd3);
    checkOutput("s6_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("s6_pre_req", 32'(im_req), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("s6_async_occ", 32'(occupancy), 32'd0);
    checkOutput("s6_async_valid", 32'(out_valid), 32'd0);
    checkOutput("s6_async_req", 32'(im_req), 32'd0);
    applyReset();
    applyStimulus(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
